// File: rtl/cordic_frac_bcd.sv
// Converts a CORDIC fractional magnitude into truncated decimal digits, one
// multiply-by-10 step per clock, and scans the held result onto a 7-segment display.
module cordic_frac_bcd #(
    parameter int FRAC_W   = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [FRAC_W-1:0]     frac_in,
    input  logic                  sign_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an_out
);

    localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state_q, state_d;
    logic [FRAC_W-1:0]     f_q, f_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  pend_q, pend_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  sign_q, sign_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [K_W-1:0]        scan_q, scan_d;

    logic [FRAC_W+3:0]     p;
    logic [3:0]            digit;
    logic [4*DIGITS-1:0]   shadow_next;
    logic [3:0]            shown;

    // The integer part of f*10 is the next decimal digit; the fraction carries on.
    always_comb begin
        p     = {4'd0, f_q} * (FRAC_W+4)'(10);
        digit = p[FRAC_W+3:FRAC_W];
        shadow_next = shadow_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (k_q == K_W'(i)) begin
                shadow_next[4*(DIGITS-1-i) +: 4] = digit;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        bcd_d    = bcd_q;
        sign_d   = sign_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    f_d     = frac_in;
                    pend_d  = sign_in;
                    k_d     = '0;
                    state_d = CONV;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                f_d      = p[FRAC_W-1:0];
                k_d      = k_q + K_W'(1);
                shadow_d = shadow_next;
                // The last digit goes straight into the visible result on the way to DONE.
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    bcd_d   = shadow_next;
                    sign_d  = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CONV);
        done_d = (state_d == DONE);
    end

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        scan_d = scan_q;
        if (div_q == DIV_LAST) begin
            scan_d = (scan_q == K_LAST) ? '0 : scan_q + K_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            f_q      <= '0;
            k_q      <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= '0;
            scan_q   <= '0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            bcd_q    <= bcd_d;
            sign_q   <= sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div_q    <= div_d;
            scan_q   <= scan_d;
        end
    end

    // Display decode follows the scan index directly so each digit gets whole divider periods.
    always_comb begin
        shown  = 4'd0;
        an_out = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_q == K_W'(i)) begin
                shown = bcd_q[4*(DIGITS-1-i) +: 4];
                an_out[DIGITS-1-i] = 1'b0;
            end
        end
        case (shown)
            4'd0:    seg_out = 7'b1000000;
            4'd1:    seg_out = 7'b1111001;
            4'd2:    seg_out = 7'b0100100;
            4'd3:    seg_out = 7'b0110000;
            4'd4:    seg_out = 7'b0011001;
            4'd5:    seg_out = 7'b0010010;
            4'd6:    seg_out = 7'b0000010;
            4'd7:    seg_out = 7'b1111000;
            4'd8:    seg_out = 7'b0000000;
            4'd9:    seg_out = 7'b0010000;
            default: seg_out = 7'b1111111;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign sign_out = sign_q;

endmodule

// File: tb/tb_cordic_frac_bcd.sv
// Directed and randomized checks of cordic_frac_bcd against a decimal-arithmetic
// reference model of the truncated fraction and the display scan.
module tb_cordic_frac_bcd;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [13:0] frac_in;
    logic        sign_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        sign_out;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;

    int errors = 0;
    int checks = 0;

    cordic_frac_bcd #(.FRAC_W(14), .DIGITS(4), .SCAN_DIV(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .frac_in  (frac_in),
        .sign_in  (sign_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sign_out (sign_out),
        .seg_out  (seg_out),
        .an_out   (an_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncated first four decimal digits of f / 2^14, packed as BCD.
    function automatic logic [15:0] expBcd(input logic [13:0] f);
        int v;
        v = (int'(f) * 10000) / 16384;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] segCode(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d < 4'd10) ? tbl[d] : 7'b1111111;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [13:0] f, input logic s);
        @(negedge clk);
        start   = st;
        frac_in = f;
        sign_in = s;
    endtask

    // Full conversion: checks latency, busy width, result, sign and the done pulse width.
    task automatic doConv(input logic [13:0] f, input logic s, input string tag);
        int edges;
        int busyCnt;
        applyStimulus(1'b1, f, s);
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        frac_in = 14'($urandom);
        sign_in = ~s;
        edges   = 1;
        busyCnt = 0;
        while (!done && edges < 20) begin
            if (busy) busyCnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'd5);
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'd4);
        checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'(expBcd(f)));
        checkOutput({tag, "_sign"}, 32'(sign_out), 32'(s));
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_idlebusy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0]  prevAn;
        logic [13:0] cur;
        logic [15:0] gotBcd;
        int          found;
        int          doneCnt;
        int          lastDone;

        reset_n = 1'b0;
        start   = 1'b0;
        frac_in = '0;
        sign_in = 1'b0;

        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_bcd", 32'(bcd_out), 32'd0);
        checkOutput("reset_sign", 32'(sign_out), 32'd0);
        checkOutput("reset_an", 32'(an_out), 32'b0111);
        checkOutput("reset_seg", 32'(seg_out), 32'b1000000);
        @(negedge clk);
        reset_n = 1'b1;

        doConv(14'h2000, 1'b0, "half");
        doConv(14'h2D41, 1'b1, "sqrt_half");
        found = 0;
        for (int c = 0; c < 80 && found == 0; c++) begin
            @(negedge clk);
            if (an_out == 4'b0111) found = 1;
        end
        checkOutput("seg7_found", 32'(found), 32'd1);
        checkOutput("seg7_code", 32'(seg_out), 32'b1111000);

        doConv(14'h0001, 1'b0, "tiny");
        doConv(14'h1000, 1'b1, "quarter");
        doConv(14'h3FFF, 1'b0, "max");

        // Reset two cycles into a conversion drops it without a done pulse.
        applyStimulus(1'b1, 14'h2D41, 1'b1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_bcd", 32'(bcd_out), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        doneCnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("midreset_nodone", 32'(doneCnt), 32'd0);
        doConv(14'h1000, 1'b0, "after_reset");

        // A start pulse during CONV must not disturb the running conversion.
        applyStimulus(1'b1, 14'h2D41, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b1;
        frac_in = 14'h3FFF;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        doneCnt = 0;
        gotBcd  = '0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                doneCnt++;
                gotBcd = bcd_out;
            end
            @(negedge clk);
        end
        checkOutput("ignore_donecount", 32'(doneCnt), 32'd1);
        checkOutput("ignore_bcd", 32'(gotBcd), 32'h7070);

        // start held high: each acceptance in DONE takes the frac_in present at that edge.
        cur = 14'($urandom);
        applyStimulus(1'b1, cur, 1'b0);
        doneCnt  = 0;
        lastDone = -1;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                checkOutput("held_bcd", 32'(bcd_out), 32'(expBcd(cur)));
                if (lastDone >= 0) checkOutput("held_period", 32'(c - lastDone), 32'd5);
                lastDone = c;
                doneCnt++;
                cur      = 14'($urandom);
                frac_in  = cur;
            end else begin
                frac_in = 14'($urandom);
            end
        end
        checkOutput("held_donecount", 32'(doneCnt), 32'd5);
        start = 1'b0;
        repeat (6) @(negedge clk);

        for (int n = 0; n < 12; n++) begin
            doConv(14'($urandom), 1'($urandom), $sformatf("rand%0d", n));
        end

        // Scan sequence over one full refresh after a 0.5000 result.
        doConv(14'h2000, 1'b0, "scan_setup");
        found  = 0;
        prevAn = an_out;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (an_out == 4'b0111 && prevAn == 4'b1110) found = 1;
            prevAn = an_out;
        end
        checkOutput("scan_sync", 32'(found), 32'd1);
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 16; j++) begin
                checkOutput($sformatf("scan_an_d%0d", d), 32'(an_out), 32'(4'b1000 >> d) ^ 32'hF);
                checkOutput($sformatf("scan_seg_d%0d", d), 32'(seg_out),
                            32'(segCode((d == 0) ? 4'd5 : 4'd0)));
                @(negedge clk);
            end
        end
        checkOutput("scan_wrap", 32'(an_out), 32'b0111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
